// File: rtl/f_fetch_unit_pkg.sv
// Shared constants for the P7 fetch stage: next-PC select codes, exception
// codes and the fixed fetch address map.
package f_fetch_unit_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  localparam logic [3:0]  EXC_NONE  = 4'd0;
  localparam logic [3:0]  EXC_ADEL  = 4'd4;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO   = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI   = 32'h0000_6ffc;

endpackage

// File: rtl/f_npc_calc.sv
// Combinational next-PC mux for the fetch stage. Branch and jump targets are
// formed from the D-stage instruction, which owns the delay slot now in F.
module f_npc_calc
  import f_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_f_i,
  input  logic [1:0]  npc_op_i,
  input  logic        br_taken_i,
  input  logic [31:0] pc_d_i,
  input  logic [25:0] imm26_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] npc_o
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;

  assign seq_pc = pc_f_i + 32'd4;
  assign br_off = {{14{imm26_i[15]}}, imm26_i[15:0], 2'b00};

  always_comb begin
    npc_o = seq_pc;
    case (npc_op_i)
      NPC_SEQ: npc_o = seq_pc;
      NPC_BR:  npc_o = br_taken_i ? (pc_d_i + 32'd4 + br_off) : seq_pc;
      NPC_J:   npc_o = {pc_d_i[31:28], imm26_i, 2'b00};
      NPC_JR:  npc_o = rs_val_i;
      default: npc_o = seq_pc;
    endcase
  end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: architectural PC register, next-PC selection, AdEL check on the
// fetch address and the F-side payload handed to the F/D register.
module f_fetch_unit
  import f_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        md_busy,
  input  logic        req,
  input  logic        eret_d,
  input  logic [31:0] epc,
  input  logic [1:0]  npc_op_d,
  input  logic        br_taken_d,
  input  logic [31:0] pc_d,
  input  logic [25:0] imm26_d,
  input  logic [31:0] rs_val_d,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_f,
  output logic [3:0]  f_exccode,
  output logic        bd_f
);

  logic [31:0] pc_f_q;
  logic [31:0] pc_f_d;
  logic [31:0] npc;
  logic        hold;
  logic        adel;
  logic        squash;

  f_npc_calc u_npc_calc (
    .pc_f_i     (pc_f_q),
    .npc_op_i   (npc_op_d),
    .br_taken_i (br_taken_d),
    .pc_d_i     (pc_d),
    .imm26_i    (imm26_d),
    .rs_val_i   (rs_val_d),
    .npc_o      (npc)
  );

  assign hold = stall | md_busy;

  // Exception entry beats any freeze; a frozen eret must not redirect yet.
  always_comb begin
    pc_f_d = pc_f_q;
    if (req) begin
      pc_f_d = EXC_ENTRY;
    end else if (hold) begin
      pc_f_d = pc_f_q;
    end else if (eret_d) begin
      pc_f_d = epc;
    end else begin
      pc_f_d = npc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q <= PC_RESET;
    end else begin
      pc_f_q <= pc_f_d;
    end
  end

  assign adel   = (pc_f_q[1:0] != 2'b00) || (pc_f_q < IMEM_LO) || (pc_f_q > IMEM_HI);
  // eret has no delay slot, so whatever was fetched behind it is discarded.
  assign squash = eret_d & ~hold;

  always_comb begin
    instr_f   = i_inst_rdata;
    f_exccode = EXC_NONE;
    if (squash) begin
      instr_f   = 32'd0;
      f_exccode = EXC_NONE;
    end else if (adel) begin
      instr_f   = 32'd0;
      f_exccode = EXC_ADEL;
    end
  end

  assign bd_f        = (npc_op_d != NPC_SEQ) & ~eret_d;
  assign pc_f        = pc_f_q;
  assign i_inst_addr = pc_f_q;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Bench for f_fetch_unit: directed vector table for the corner cases, then
// random traffic checked against a cycle-level model of the fetch rules.
module tb_f_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        md_busy;
  logic        req;
  logic        eret_d;
  logic [31:0] epc;
  logic [1:0]  npc_op_d;
  logic        br_taken_d;
  logic [31:0] pc_d;
  logic [25:0] imm26_d;
  logic [31:0] rs_val_d;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [3:0]  f_exccode;
  logic        bd_f;

  f_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .md_busy      (md_busy),
    .req          (req),
    .eret_d       (eret_d),
    .epc          (epc),
    .npc_op_d     (npc_op_d),
    .br_taken_d   (br_taken_d),
    .pc_d         (pc_d),
    .imm26_d      (imm26_d),
    .rs_val_d     (rs_val_d),
    .i_inst_rdata (i_inst_rdata),
    .i_inst_addr  (i_inst_addr),
    .pc_f         (pc_f),
    .instr_f      (instr_f),
    .f_exccode    (f_exccode),
    .bd_f         (bd_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'd1;
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  typedef struct {
    logic        rst, stl, md, rq, er;
    logic [31:0] ep;
    logic [1:0]  op;
    logic        br;
    logic [31:0] pcd;
    logic [25:0] imm;
    logic [31:0] rs;
    logic        chk;
    logic [31:0] e_pc;
    logic [3:0]  e_exc;
    logic        e_bd;
    logic        e_nop;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [31:0] m_pc;
  bit          m_valid = 0;

  task automatic add(input logic rst, stl, md, rq, er, input logic [31:0] ep,
                     input logic [1:0] op, input logic br, input logic [31:0] pcd,
                     input logic [25:0] imm, input logic [31:0] rs, input logic chk,
                     input logic [31:0] e_pc, input logic [3:0] e_exc,
                     input logic e_bd, input logic e_nop);
    vec_t v;
    v.rst = rst; v.stl = stl; v.md = md; v.rq = rq; v.er = er; v.ep = ep;
    v.op = op; v.br = br; v.pcd = pcd; v.imm = imm; v.rs = rs; v.chk = chk;
    v.e_pc = e_pc; v.e_exc = e_exc; v.e_bd = e_bd; v.e_nop = e_nop;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules for where the PC goes next, stated directly.
  function automatic logic [31:0] model_next(input vec_t v, input logic [31:0] cur);
    int off;
    if (v.rst) return 32'h0000_3000;
    if (v.rq) return 32'h0000_4180;
    if (v.stl || v.md) return cur;
    if (v.er) return v.ep;
    off = int'($signed(v.imm[15:0])) * 4;
    case (v.op)
      2'd1:    return v.br ? v.pcd + 32'd4 + 32'(off) : cur + 32'd4;
      2'd2:    return (v.pcd & 32'hF000_0000) | (32'(v.imm) * 4);
      2'd3:    return v.rs;
      default: return cur + 32'd4;
    endcase
  endfunction

  task automatic apply(input vec_t v, input bit use_tbl);
    logic [31:0] x_pc, x_instr;
    logic [3:0]  x_exc;
    logic        x_bd, bad, sq;
    @(negedge clk);
    reset = v.rst; stall = v.stl; md_busy = v.md; req = v.rq; eret_d = v.er;
    epc = v.ep; npc_op_d = v.op; br_taken_d = v.br; pc_d = v.pcd;
    imm26_d = v.imm; rs_val_d = v.rs;
    #1;
    bad = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6ffc);
    sq  = v.er && !(v.stl || v.md);
    x_pc    = m_pc;
    x_exc   = (!sq && bad) ? 4'd4 : 4'd0;
    x_instr = (sq || bad) ? 32'd0 : mem_word(m_pc);
    x_bd    = (v.op != 2'd0) && !v.er;
    if (use_tbl) begin
      x_pc    = v.e_pc;
      x_exc   = v.e_exc;
      x_bd    = v.e_bd;
      x_instr = v.e_nop ? 32'd0 : mem_word(v.e_pc);
    end
    if ((use_tbl && v.chk) || (!use_tbl && m_valid)) begin
      n_vec++;
      cmp("pc_f", pc_f, x_pc);
      cmp("i_inst_addr", i_inst_addr, x_pc);
      cmp("f_exccode", {28'd0, f_exccode}, {28'd0, x_exc});
      cmp("bd_f", {31'd0, bd_f}, {31'd0, x_bd});
      cmp("instr_f", instr_f, x_instr);
    end
    @(posedge clk);
    if (v.rst) m_valid = 1;
    m_pc = model_next(v, m_pc);
  endtask

  initial begin
    vec_t v;
    reset = 1; stall = 0; md_busy = 0; req = 0; eret_d = 0; epc = 0;
    npc_op_d = 0; br_taken_d = 0; pc_d = 0; imm26_d = 0; rs_val_d = 0;
    m_pc = 32'h0;

    //  rst stl md rq er  epc          op br pcd           imm           rs          chk  pc           exc bd nop
    add(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        0, 32'h0,        0, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3000,     0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3000,     0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3004,     0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3008,     0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h3010,     26'h000FFFC,  32'h0,        1, 32'h300C,     0, 1, 0);
    add(0, 0, 0, 0, 0, 32'h0,        1, 0, 32'h3010,     26'h000FFFC,  32'h0,        1, 32'h3004,     0, 1, 0);
    add(0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3008,     0, 0, 0);
    add(0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3008,     0, 0, 0);
    add(0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3008,     0, 0, 0);
    add(0, 1, 0, 1, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3008,     0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h3020,     0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h4180,     0, 0, 1);
    add(0, 0, 0, 0, 0, 32'h0,        3, 0, 32'h0,        26'h0,        32'h3002,     1, 32'h3020,     0, 1, 0);
    add(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3002,     4, 0, 1);
    add(0, 0, 0, 0, 0, 32'h0,        3, 0, 32'h0,        26'h0,        32'h7000,     1, 32'h3006,     4, 1, 1);
    add(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h7000,     4, 0, 1);
    add(0, 0, 1, 0, 0, 32'h0,        2, 0, 32'h1234_5678, 26'h0000C04, 32'h0,        1, 32'h7004,     4, 1, 1);
    add(0, 0, 0, 0, 0, 32'h0,        2, 0, 32'h1234_5678, 26'h0000C04, 32'h0,        1, 32'h7004,     4, 1, 1);
    add(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h1000_3010, 4, 0, 1);
    add(1, 1, 0, 1, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h1000_3014, 4, 0, 1);
    add(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3000,     0, 0, 0);
    add(0, 1, 0, 0, 1, 32'h3100,     0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3004,     0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h3100,     0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h3004,     0, 0, 1);
    add(0, 0, 0, 0, 0, 32'h0,        3, 0, 32'h0,        26'h0,        32'h6ffc,     1, 32'h3100,     0, 1, 0);
    add(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h6ffc,     0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        3, 0, 32'h0,        26'h0,        32'h2ffc,     1, 32'h7000,     4, 1, 1);
    add(0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        26'h0,        32'h0,        1, 32'h2ffc,     4, 0, 1);

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    for (int i = 0; i < 400; i++) begin
      v.rst = ($urandom_range(0, 63) == 0);
      v.stl = ($urandom_range(0, 3) == 0);
      v.md  = ($urandom_range(0, 7) == 0);
      v.rq  = ($urandom_range(0, 15) == 0);
      v.er  = ($urandom_range(0, 7) == 0);
      v.ep  = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2) + ($urandom_range(0, 7) == 0 ? 32'd2 : 32'd0);
      v.op  = 2'($urandom_range(0, 3));
      v.br  = 1'($urandom_range(0, 1));
      v.pcd = ($urandom_range(0, 3) == 0) ? $urandom() : m_pc - 32'd4;
      v.imm = 26'($urandom());
      v.rs  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'h3000 + ($urandom_range(0, 32'h1000) << 2);
      v.chk = 1'b0; v.e_pc = 32'h0; v.e_exc = 4'h0; v.e_bd = 1'b0; v.e_nop = 1'b0;
      apply(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
